// File: rtl/clk_div_prog.sv
// Programmable clock divider producing a 50% duty clk_out for any ratio N >= 2.
// For odd N a falling-edge flop stretches the high phase by half a clk cycle.
module clk_div_prog #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [WIDTH-1:0] div_ratio,
    output logic             clk_out,
    output logic             period_start,
    output logic             busy,
    output logic [WIDTH-1:0] ratio_active
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] RATIO_MIN = WIDTH'(2);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ratio_q, ratio_d;
    logic             p_q, p_d;
    logic             ps_q, ps_d;
    logic             n_q;

    logic [WIDTH-1:0] ratio_san;
    logic             wrap;

    assign ratio_san = (div_ratio < RATIO_MIN) ? RATIO_MIN : div_ratio;
    assign wrap      = (cnt_q == ratio_q - WIDTH'(1));

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ratio_d = ratio_q;
        p_d     = p_q;
        ps_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                p_d   = 1'b0;
                if (en) begin
                    state_d = RUN;
                    ratio_d = ratio_san;
                    p_d     = 1'b1;
                    ps_d    = 1'b1;
                end
            end
            RUN: begin
                if (wrap) begin
                    cnt_d = '0;
                    // A new period always opens high: cnt 0 is below H for every N >= 2.
                    if (en) begin
                        ratio_d = ratio_san;
                        p_d     = 1'b1;
                        ps_d    = 1'b1;
                    end else begin
                        state_d = IDLE;
                        p_d     = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                    p_d   = (cnt_q + WIDTH'(1)) < (ratio_q >> 1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ratio_q <= RATIO_MIN;
            p_q     <= 1'b0;
            ps_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
            p_q     <= p_d;
            ps_q    <= ps_d;
        end
    end

    // Half-cycle extension of the high phase; held at 0 for even ratios.
    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            n_q <= 1'b0;
        end else begin
            n_q <= ratio_q[0] & p_q;
        end
    end

    assign clk_out      = p_q | n_q;
    assign period_start = ps_q;
    assign busy         = (state_q == RUN);
    assign ratio_active = ratio_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed + randomised bench for clk_div_prog: measures every clk_out period in
// half-cycles and compares against ratios queued by the stimulus.
module tb_clk_div_prog;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic [7:0] div_ratio;
    logic       clk_out;
    logic       period_start;
    logic       busy;
    logic [7:0] ratio_active;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    clk_div_prog #(.WIDTH(8)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .en           (en),
        .div_ratio    (div_ratio),
        .clk_out      (clk_out),
        .period_start (period_start),
        .busy         (busy),
        .ratio_active (ratio_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int san(input int r);
        return (r < 2) ? 2 : r;
    endfunction

    // Monitor: sample 1 time unit after every clk edge and measure clk_out in half cycles.
    int   hi_cnt, lo_cnt, cur_exp;
    logic in_per = 1'b0, prev_clk = 1'b0, prev_busy = 1'b0, rise;

    task automatic close_period();
        check("high_halves", hi_cnt, cur_exp);
        check("low_halves", lo_cnt, cur_exp);
    endtask

    always @(posedge clk or negedge clk) begin
        #1;
        if (!rstn) begin
            in_per    = 1'b0;
            prev_clk  = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (clk) begin
                rise = clk_out & ~prev_clk;
                check("period_start", period_start, rise);
                if (rise) begin
                    if (in_per) close_period();
                    check("pending_expect", exp_q.size() > 0, 1);
                    cur_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
                    check("ratio_active", ratio_active, cur_exp);
                    check("busy_at_start", busy, 1);
                    hi_cnt = 0;
                    lo_cnt = 0;
                    in_per = 1'b1;
                end else if (prev_busy && !busy) begin
                    if (in_per) close_period();
                    in_per = 1'b0;
                end
            end
            if (in_per) begin
                if (clk_out) hi_cnt++;
                else         lo_cnt++;
            end
            prev_clk  = clk_out;
            prev_busy = busy;
        end
    end

    // Called at a falling edge while idle; returns at the falling edge inside cnt=0.
    task automatic start(input int r);
        en        = 1'b1;
        div_ratio = 8'(r);
        exp_q.push_back(san(r));
        @(negedge clk);
    endtask

    // Runs one period of ratio n from its cnt=0 cycle; nxt is applied at cnt=chg_at,
    // en drops at cnt=drop_at, and keep decides en at the wrap edge.
    task automatic period(input int n, input int nxt, input bit keep, input int drop_at,
                          input int chg_at);
        for (int c = 0; c < n; c++) begin
            if (c == 0) div_ratio = 8'($urandom_range(0, 255));
            if (c == chg_at) div_ratio = 8'(nxt);
            if (c == drop_at) en = 1'b0;
            if (c == n - 1) begin
                en = keep;
                if (keep) exp_q.push_back(san(nxt));
            end
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_clk_out"}, clk_out, 0);
        check({tag, "_period_start"}, period_start, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cur;
        int nxt;
        rstn      = 1'b0;
        en        = 1'b0;
        div_ratio = 8'd0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset_ratio_active", ratio_active, 2);
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle("post_reset_idle");
        end

        // Steady 9, change 9->4 at cnt=3, then 4, then ratio 1 sanitised to 2.
        start(9);
        period(9, 9, 1'b1, -1, 0);
        period(9, 4, 1'b1, -1, 3);
        period(4, 4, 1'b1, -1, 0);
        period(4, 1, 1'b1, -1, 0);
        period(2, 0, 1'b1, -1, 0);
        period(2, 7, 1'b1, -1, 0);
        // en falls at cnt=2 with N=7: period completes, then idle.
        period(7, 7, 1'b0, 2, 0);
        check_idle("drain7");
        @(negedge clk);
        check_idle("drain7_hold");

        // en dropped and re-asserted before the wrap: no interruption.
        start(5);
        period(5, 6, 1'b1, 1, 0);
        period(6, 6, 1'b0, -1, 0);
        check_idle("drain6");

        // Sweep 2..15 (with 0/1 sanitised) and random mid-period changes.
        cur = san($urandom_range(0, 15));
        start(cur);
        for (int k = 0; k < 24; k++) begin
            nxt = $urandom_range(0, 15);
            period(cur, nxt, 1'b1, -1, $urandom_range(0, cur - 1));
            cur = san(nxt);
        end
        period(cur, cur, 1'b0, -1, 0);
        check_idle("drain_sweep");

        // Asynchronous reset while clk_out is high with N=9.
        start(9);
        @(negedge clk);
        check("pre_reset_clk_out", clk_out, 1);
        #2 rstn = 1'b0;
        #1;
        check_idle("async_reset");
        check("async_reset_ratio_active", ratio_active, 2);
        en        = 1'b1;
        div_ratio = 8'd9;
        exp_q.push_back(9);
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        period(9, 9, 1'b1, -1, 0);
        period(9, 9, 1'b0, -1, 0);
        check_idle("drain_after_reset");

        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001: Parameter WIDTH, default 8: width of the ratio port and counter; maximum ratio 2^WIDTH-1.
REQ-002: clk  input  1  Single source clock; rising edge is the primary edge, falling edge used only by the odd-ratio half-cycle flop.
REQ-003: rstn  input  1  Asynchronous, active-low reset.
REQ-004: en  input  1  Run request, sampled on clk rising edge.
REQ-005: div_ratio  input  WIDTH  Requested divide ratio N, odd or even.
REQ-006: clk_out  output  1  Divided clock, 50% duty for all N.
REQ-007: period_start  output  1  One clk-cycle pulse marking each clk_out period start.
REQ-008: busy  output  1  High while the divider is running, including the drain period after en falls.
REQ-009: ratio_active  output  WIDTH  Ratio currently in effect, after sanitising.

Function
REQ-010: Sanitise: div_ratio of 0 or 1 SHALL be treated as 2; every other value is used as-is.
REQ-011: Idle (busy=0): cnt=0, posedge flop p=0, negedge flop n=0, clk_out=0.
REQ-012: At the first rising edge with en=1 while idle, the block SHALL set busy=1, cnt=0, p=1 and period_start=1, and load ratio_active from sanitised div_ratio.
REQ-013: While running, cnt SHALL increment by 1 per rising edge and wrap from ratio_active-1 to 0.
REQ-014: ratio_active SHALL reload from sanitised div_ratio only at the wrap edge; changes to div_ratio mid-period SHALL have no effect until the next period.
REQ-015: Define H = N/2 when N is even and H = (N-1)/2 when N is odd.
REQ-016: p SHALL be registered with next value (cnt_next < H), evaluated with the N in effect for cnt_next.
REQ-017: n SHALL capture p on each clk falling edge when N is odd, and SHALL be forced to 0 when N is even.
REQ-018: clk_out SHALL be p OR n, giving high H+0.5 clk cycles and low N-H-0.5 clk cycles for odd N, and exactly N/2 high and N/2 low for even N.
REQ-019: period_start SHALL be registered high for exactly the cycle following each edge at which cnt becomes 0, coincident with the rising edge of clk_out.
REQ-020: en=0 while running: the block SHALL finish the current period, and at the wrap edge go idle (busy=0, p=0); no truncated high or low phase.
REQ-021: en re-asserted before the drain wrap: the block SHALL continue without interruption.
REQ-022: Odd/even change at a wrap: n SHALL follow the new mode from that edge; no pulse narrower than 1 clk cycle SHALL occur.
REQ-023: clk_out SHALL be generated only from flop outputs and the single OR gate; no combinational path from clk to clk_out.

Reset
REQ-024: rstn low SHALL immediately clear cnt, p, n, busy and period_start, SHALL set ratio_active=2, and SHALL force clk_out=0, including mid-period.
REQ-025: After rstn rises, the block SHALL stay idle until en is sampled high.

Verification
REQ-026: div_ratio=9, en=1 steady -> clk_out period 9 clk cycles, high 4.5, low 4.5; period_start every 9 cycles.
REQ-027: div_ratio=4 -> high 2, low 2, n stays 0; div_ratio=1 -> behaves as 2, ratio_active=2.
REQ-028: Change 9->4 at cnt=3 -> current period completes as 9 (4.5/4.5), next period 4 (2/2), ratio_active updates at the wrap edge.
REQ-029: en falls at cnt=2 with N=7 -> period completes (3.5 high, 3.5 low), then busy=0 and clk_out=0.
REQ-030: rstn asserted while clk_out=1 with N=9 -> clk_out=0 asynchronously; after release with en=1, first period starts cleanly with period_start pulse.
REQ-031: Sweep N=2..15 with random mid-period ratio changes -> no clk_out pulse under 1 clk cycle; duty exact per REQ-018.
